lane_scheduler: RTL and testbench

//  Sequences the PHY transmit path. Brings the link up by sending COM (0xBC) training symbols until the receiver reports active.

---
 rtl/lane_scheduler_pkg.sv | 31 +++
 rtl/lane_scheduler_arbiter.sv | 34 +++
 rtl/lane_scheduler.sv | 161 ++++++++++++++++
 tb/tb_lane_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_scheduler_pkg.sv
// Shared symbols, link states and the registered output bundle
// for the PHY transmit lane scheduler.
package lane_scheduler_pkg;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  localparam logic [1:0] ST_TRAIN = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       k;
    logic       ins;
  } tx_out_t;

  function automatic tx_out_t ctrl_sym(
    input logic [7:0] sym,
    input logic       ins
  );
    tx_out_t o;
    o.data  = sym;
    o.valid = 1'b0;
    o.k     = 1'b1;
    o.ins   = ins;
    return o;
  endfunction

endpackage

// File: rtl/lane_scheduler_arbiter.sv
// Four-way round-robin arbiter; optionally re-grants the
// pointer lane to sustain a burst.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       hold,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    cand    = ptr;
    if (hold && req[ptr]) begin
      gnt[ptr] = 1'b1;
      found    = 1'b1;
    end
    // search ptr+1 .. ptr+4; the last step wraps back to ptr
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/lane_scheduler.sv
// Link training FSM plus round-robin byte-slot sharing among
// four lanes, feeding the parallel-to-serial stage.
module lane_scheduler
  import lane_scheduler_pkg::*;
#(
  parameter int TRAIN_CYC = 16,
  parameter int TIMEOUT   = 64,
  parameter int BURST_MAX = 1
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0p,
  input  logic [7:0] data_1p,
  input  logic [7:0] data_2p,
  input  logic [7:0] data_3p,
  input  logic       valid_0p,
  input  logic       valid_1p,
  input  logic       valid_2p,
  input  logic       valid_3p,
  input  logic       active,
  output logic       ready_0p,
  output logic       ready_1p,
  output logic       ready_2p,
  output logic       ready_3p,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       k_out,
  output logic       inserter,
  output logic [1:0] link_state
);

  localparam int TW = (TRAIN_CYC > 1) ? $clog2(TRAIN_CYC) : 1;
  localparam int OW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYC - 1);
  localparam logic [OW-1:0] TO_LAST    = OW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] train_cnt_q, train_cnt_d;
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          gnt_last_q, gnt_last_d;
  tx_out_t       out_q, out_d;

  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       hold;
  logic       run_ok;
  logic [3:0] ready;
  logic [7:0] lane_data [4];

  assign req = {valid_3p, valid_2p, valid_1p, valid_0p};

  assign lane_data[0] = data_0p;
  assign lane_data[1] = data_1p;
  assign lane_data[2] = data_2p;
  assign lane_data[3] = data_3p;

  assign hold = gnt_last_q && (burst_cnt_q < BURST_LIM);

  rr_arbiter_4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .hold    (hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // a reset or an active drop in the same cycle kills the grant
  assign run_ok = (state_q == ST_RUN) && active && !reset;
  assign ready  = gnt & {4{run_ok}};

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    to_cnt_d    = to_cnt_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_last_d  = 1'b0;
    out_d       = ctrl_sym(COM, 1'b0);
    unique case (1'b1)
      (state_q == ST_TRAIN): begin
        if (train_cnt_q == TRAIN_LAST) begin
          state_d     = ST_WAIT;
          train_cnt_d = '0;
        end else begin
          train_cnt_d = train_cnt_q + TW'(1);
        end
      end
      (state_q == ST_WAIT): begin
        if (active) begin
          state_d  = ST_RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_TRAIN;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + OW'(1);
        end
      end
      (state_q == ST_RUN): begin
        if (!active) begin
          state_d = ST_TRAIN;
        end else if (|gnt) begin
          out_d.data  = lane_data[gnt_idx];
          out_d.valid = 1'b1;
          out_d.k     = 1'b0;
          out_d.ins   = 1'b0;
          ptr_d       = gnt_idx;
          gnt_last_d  = 1'b1;
          if (hold && req[ptr_q]) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end else begin
            burst_cnt_d = BW'(1);
          end
        end else begin
          out_d = ctrl_sym(IDLE, 1'b1);
        end
      end
      default: begin
        state_d = ST_TRAIN;
      end
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q     <= ST_TRAIN;
      train_cnt_q <= '0;
      to_cnt_q    <= '0;
      ptr_q       <= 2'd3;
      burst_cnt_q <= '0;
      gnt_last_q  <= 1'b0;
      out_q       <= '{data: 8'h00, valid: 1'b0,
                       k: 1'b0, ins: 1'b0};
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_last_q  <= gnt_last_d;
      out_q       <= out_d;
    end
  end

  assign ready_0p   = ready[0];
  assign ready_1p   = ready[1];
  assign ready_2p   = ready[2];
  assign ready_3p   = ready[3];
  assign data_out   = out_q.data;
  assign valid_out  = out_q.valid;
  assign k_out      = out_q.k;
  assign inserter   = out_q.ins;
  assign link_state = state_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Scenario bench for lane_scheduler: one instance with single
// grants, one with bursts of three, sharing the lane inputs.
module tb_lane_scheduler;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam logic [1:0] S_TR = 2'd0;
  localparam logic [1:0] S_WT = 2'd1;
  localparam logic [1:0] S_RN = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic       active;

  logic       a_r0, a_r1, a_r2, a_r3;
  logic [7:0] a_data;
  logic       a_valid, a_k, a_ins;
  logic [1:0] a_state;
  logic       b_r0, b_r1, b_r2, b_r3;
  logic [7:0] b_data;
  logic       b_valid, b_k, b_ins;
  logic [1:0] b_state;

  logic [3:0] ra, rb;
  assign ra = {a_r3, a_r2, a_r1, a_r0};
  assign rb = {b_r3, b_r2, b_r1, b_r0};

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  lane_scheduler #(.TRAIN_CYC(16), .TIMEOUT(64), .BURST_MAX(1)) u_b1 (
    .clk_4f(clk), .reset(reset),
    .data_0p(d0), .data_1p(d1), .data_2p(d2), .data_3p(d3),
    .valid_0p(v0), .valid_1p(v1), .valid_2p(v2), .valid_3p(v3),
    .active(active),
    .ready_0p(a_r0), .ready_1p(a_r1), .ready_2p(a_r2), .ready_3p(a_r3),
    .data_out(a_data), .valid_out(a_valid), .k_out(a_k),
    .inserter(a_ins), .link_state(a_state)
  );

  lane_scheduler #(.TRAIN_CYC(16), .TIMEOUT(64), .BURST_MAX(3)) u_b3 (
    .clk_4f(clk), .reset(reset),
    .data_0p(d0), .data_1p(d1), .data_2p(d2), .data_3p(d3),
    .valid_0p(v0), .valid_1p(v1), .valid_2p(v2), .valid_3p(v3),
    .active(active),
    .ready_0p(b_r0), .ready_1p(b_r1), .ready_2p(b_r2), .ready_3p(b_r3),
    .data_out(b_data), .valid_out(b_valid), .k_out(b_k),
    .inserter(b_ins), .link_state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [3:0] v);
    {v3, v2, v1, v0} = v;
  endtask

  // reset, then train up to WAIT and raise active: RUN next edge
  task automatic go_run();
    active = 1'b0;
    set_valid(4'b0000);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (16) tick();
    active = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    active = 1'b1;
    set_valid(4'b1111);
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_state, a_data, a_valid, a_k, a_ins} !==
        {S_TR, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_out: got st=%0d d=%h v=%b k=%b i=%b want st=0 d=00 v=0 k=0 i=0",
               a_state, a_data, a_valid, a_k, a_ins);
    end
    checks++;
    if ({ra, rb} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 0000/0000", ra, rb);
    end
  endtask

  task automatic test_training();
    logic [1:0] es;
    int bad;
    active = 1'b0;
    set_valid(4'b0000);
    reset = 1'b0;
    bad = 0;
    for (int i = 1; i <= 84; i++) begin
      tick();
      es = (i < 16) ? S_TR : ((i < 80) ? S_WT : S_TR);
      checks++;
      if ({a_state, a_data, a_valid, a_k, a_ins} !==
          {es, COM, 3'b010}) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL train_c%0d: got st=%0d d=%h v=%b k=%b i=%b want st=%0d d=bc v=0 k=1 i=0",
                   i, a_state, a_data, a_valid, a_k, a_ins, es);
      end
    end
  endtask

  task automatic test_idle();
    go_run();
    checks++;
    if (a_state !== S_RN || ra !== 4'b0000) begin
      errors++;
      $display("FAIL enter_run: got st=%0d rdy=%b want st=2 rdy=0000", a_state, ra);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({a_data, a_valid, a_k, a_ins, ra} !== {IDLE, 3'b011, 4'b0000}) begin
        errors++;
        $display("FAIL idle_%0d: got d=%h v=%b k=%b i=%b rdy=%b want d=7c v=0 k=1 i=1 rdy=0000",
                 i, a_data, a_valid, a_k, a_ins, ra);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    go_run();
    set_valid(4'b1111);
    #1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i % 4));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ra !== (4'b0001 << e[1:0])) begin
        errors++;
        $display("FAIL rr_ready: got %b want lane %0d", ra, e[1:0]);
      end
      tick();
      checks++;
      if ({a_data, a_valid, a_k, a_ins} !== {e, 3'b100}) begin
        errors++;
        $display("FAIL rr_data: got d=%h v=%b k=%b i=%b want d=%h v=1 k=0 i=0",
                 a_data, a_valid, a_k, a_ins, e);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] e;
    go_run();
    set_valid(4'b0110);
    #1;
    exp_q.delete();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 1) begin
        set_valid(4'b0100);
        #1;
      end
      e = exp_q.pop_front();
      checks++;
      if (rb !== (4'b0001 << e[1:0])) begin
        errors++;
        $display("FAIL burst_ready: got %b want lane %0d", rb, e[1:0]);
      end
      tick();
      checks++;
      if ({b_data, b_valid, b_k} !== {e, 2'b10}) begin
        errors++;
        $display("FAIL burst_data: got d=%h v=%b k=%b want d=%h v=1 k=0",
                 b_data, b_valid, b_k, e);
      end
    end
  endtask

  task automatic test_active_drop();
    int bad;
    go_run();
    set_valid(4'b0001);
    active = 1'b0;
    #1;
    checks++;
    if (ra !== 4'b0000) begin
      errors++;
      $display("FAIL drop_ready: got %b want 0000", ra);
    end
    tick();
    checks++;
    if ({a_state, a_data, a_valid, a_k} !== {S_TR, COM, 2'b01}) begin
      errors++;
      $display("FAIL drop_out: got st=%0d d=%h v=%b k=%b want st=0 d=bc v=0 k=1",
               a_state, a_data, a_valid, a_k);
    end
    bad = 0;
    repeat (16) begin
      tick();
      if (ra !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || a_state !== S_WT) begin
      errors++;
      $display("FAIL retrain: got st=%0d ready_cycles=%0d want st=1 ready_cycles=0",
               a_state, bad);
    end
    active = 1'b1;
    tick();
    checks++;
    if (a_state !== S_RN || ra !== 4'b0001) begin
      errors++;
      $display("FAIL regrant0: got st=%0d rdy=%b want st=2 rdy=0001", a_state, ra);
    end
    tick();
    checks++;
    if ({a_data, a_valid} !== {8'hA0, 1'b1}) begin
      errors++;
      $display("FAIL kept_byte: got d=%h v=%b want d=a0 v=1", a_data, a_valid);
    end
  endtask

  task automatic test_mid_reset();
    go_run();
    set_valid(4'b1111);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({ra, rb} !== 8'h00) begin
      errors++;
      $display("FAIL rst_ready: got %b/%b want 0000/0000", ra, rb);
    end
    tick();
    checks++;
    if ({a_state, a_data, a_valid, a_k, a_ins} !== {S_TR, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL rst_out: got st=%0d d=%h v=%b k=%b i=%b want st=0 d=00 v=0 k=0 i=0",
               a_state, a_data, a_valid, a_k, a_ins);
    end
    reset = 1'b0;
    repeat (17) tick();
    checks++;
    if (a_state !== S_RN || ra !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first: got st=%0d rdy=%b want st=2 rdy=0001", a_state, ra);
    end
    tick();
    checks++;
    if (a_data !== 8'hA0) begin
      errors++;
      $display("FAIL rst_byte: got d=%h want d=a0", a_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    active = 1'b0;
    d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
    set_valid(4'b0000);
    test_reset();
    test_training();
    test_idle();
    test_round_robin();
    test_burst();
    test_active_drop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
